// File: rtl/vga_mode_ctrl.sv
`timescale 1ns/1ps
// VGA mode controller: sequences a timing generator through a safe
// reconfiguration (wait for frame boundary, hold generator in reset, load the
// new timing table, derive quarter-band boundaries, let frames settle).
module vga_mode_ctrl #(
  parameter int BLANK_CYCLES  = 16,
  parameter int SETTLE_FRAMES = 2,
  parameter int VS_TIMEOUT    = 2000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mode_req,
  input  logic [1:0]  mode_sel,
  input  logic        vga_vs_in,
  output logic        mode_ack,
  output logic        busy,
  output logic [1:0]  cur_mode,
  output logic        gen_reset_n,
  output logic [11:0] h_total,
  output logic [11:0] h_sync,
  output logic [11:0] h_start,
  output logic [11:0] h_end,
  output logic [11:0] v_total,
  output logic [11:0] v_sync,
  output logic [11:0] v_start,
  output logic [11:0] v_end,
  output logic [11:0] v_active_14,
  output logic [11:0] v_active_24,
  output logic [11:0] v_active_34
);

  typedef enum logic [2:0] {
    IDLE, WAIT_VS, BLANK, LOAD, CALC, SETTLE, DONE
  } state_e;

  typedef struct packed {
    logic [11:0] h_total;
    logic [11:0] h_sync;
    logic [11:0] h_start;
    logic [11:0] h_end;
    logic [11:0] v_total;
    logic [11:0] v_sync;
    logic [11:0] v_start;
    logic [11:0] v_end;
  } timing_t;

  localparam int BW = $clog2(BLANK_CYCLES + 1);
  localparam int TW = $clog2(VS_TIMEOUT + 1);
  localparam int FW = $clog2(SETTLE_FRAMES + 1);

  // LOAD and CALC each hold the generator in reset for one cycle, so BLANK
  // itself lasts two cycles less than the full low pulse on gen_reset_n.
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 3);
  localparam logic [TW-1:0] TO_LAST    = TW'(VS_TIMEOUT - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(SETTLE_FRAMES - 1);

  function automatic timing_t mode_table(input logic [1:0] m);
    case (m)
      2'd0:    mode_table = '{12'd799,  12'd95,  12'd141, 12'd781,
                              12'd524,  12'd1,   12'd34,  12'd514};
      2'd1:    mode_table = '{12'd1055, 12'd127, 12'd213, 12'd1013,
                              12'd627,  12'd3,   12'd26,  12'd626};
      2'd2:    mode_table = '{12'd1649, 12'd39,  12'd259, 12'd1539,
                              12'd749,  12'd4,   12'd24,  12'd744};
      default: mode_table = '{12'd2199, 12'd43,  12'd189, 12'd2109,
                              12'd1124, 12'd4,   12'd40,  12'd1120};
    endcase
  endfunction

  state_e        state_q, state_d;
  logic [1:0]    target_q, target_d;
  logic [1:0]    cur_mode_q, cur_mode_d;
  logic          ack_pending_q, ack_pending_d;
  logic          mode_ack_q, mode_ack_d;
  logic          busy_q, busy_d;
  logic          gen_rst_n_q, gen_rst_n_d;
  logic [BW-1:0] blank_cnt_q, blank_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  timing_t       timing_q, timing_d;
  logic [11:0]   va14_q, va14_d;
  logic [11:0]   va24_q, va24_d;
  logic [11:0]   va34_q, va34_d;
  logic          vs_d1_q, vs_d2_q;
  logic          vs_fall;
  logic [11:0]   quarter;

  // Frame boundary: falling edge seen between the two registered copies.
  assign vs_fall = vs_d2_q & ~vs_d1_q;
  assign quarter = (timing_q.v_end - timing_q.v_start) >> 2;

  // Next-state, counters and output register inputs.
  always_comb begin
    // NOTE: every _d takes its _q value first so no branch can infer a latch.
    state_d       = state_q;
    target_d      = target_q;
    cur_mode_d    = cur_mode_q;
    ack_pending_d = ack_pending_q;
    mode_ack_d    = 1'b0;
    blank_cnt_d   = blank_cnt_q;
    to_cnt_d      = to_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    timing_d      = timing_q;
    va14_d        = va14_q;
    va24_d        = va24_q;
    va34_d        = va34_q;

    case (state_q)
      IDLE: begin
        to_cnt_d = '0;
        if (mode_req) begin
          if (mode_sel != cur_mode_q) begin
            target_d      = mode_sel;
            ack_pending_d = 1'b1;
            state_d       = WAIT_VS;
          end else begin
            mode_ack_d = 1'b1;
          end
        end
      end
      WAIT_VS: begin
        if (vs_fall || to_cnt_q == TO_LAST) begin
          to_cnt_d    = '0;
          blank_cnt_d = '0;
          state_d     = BLANK;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      BLANK: begin
        if (blank_cnt_q == BLANK_LAST) begin
          blank_cnt_d = '0;
          state_d     = LOAD;
        end else begin
          blank_cnt_d = blank_cnt_q + BW'(1);
        end
      end
      LOAD: begin
        timing_d = mode_table(target_q);
        state_d  = CALC;
      end
      CALC: begin
        va14_d      = timing_q.v_start + quarter;
        va24_d      = timing_q.v_start + (quarter << 1);
        va34_d      = timing_q.v_start + quarter + (quarter << 1);
        frame_cnt_d = '0;
        state_d     = SETTLE;
      end
      SETTLE: begin
        if (vs_fall) begin
          if (frame_cnt_q == FRAME_LAST) begin
            frame_cnt_d = '0;
            state_d     = DONE;
          end else begin
            frame_cnt_d = frame_cnt_q + FW'(1);
          end
        end
      end
      DONE: begin
        cur_mode_d    = target_q;
        mode_ack_d    = ack_pending_q;
        ack_pending_d = 1'b0;
        state_d       = IDLE;
      end
      default: state_d = BLANK;
    endcase

    // Both are registered from the next state so they line up with state_q.
    busy_d      = (state_d != IDLE);
    gen_rst_n_d = !(state_d inside {BLANK, LOAD, CALC});
  end

  // State, counters and all registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register sees pre-edge values.
    if (reset) begin
      state_q       <= BLANK;
      target_q      <= 2'd0;
      cur_mode_q    <= 2'd0;
      ack_pending_q <= 1'b0;
      mode_ack_q    <= 1'b0;
      busy_q        <= 1'b1;
      gen_rst_n_q   <= 1'b0;
      blank_cnt_q   <= '0;
      to_cnt_q      <= '0;
      frame_cnt_q   <= '0;
      timing_q      <= mode_table(2'd0);
      va14_q        <= 12'd154;
      va24_q        <= 12'd274;
      va34_q        <= 12'd394;
      vs_d1_q       <= 1'b0;
      vs_d2_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      cur_mode_q    <= cur_mode_d;
      ack_pending_q <= ack_pending_d;
      mode_ack_q    <= mode_ack_d;
      busy_q        <= busy_d;
      gen_rst_n_q   <= gen_rst_n_d;
      blank_cnt_q   <= blank_cnt_d;
      to_cnt_q      <= to_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      timing_q      <= timing_d;
      va14_q        <= va14_d;
      va24_q        <= va24_d;
      va34_q        <= va34_d;
      vs_d1_q       <= vga_vs_in;
      vs_d2_q       <= vs_d1_q;
    end
  end

  assign mode_ack    = mode_ack_q;
  assign busy        = busy_q;
  assign cur_mode    = cur_mode_q;
  assign gen_reset_n = gen_rst_n_q;
  assign h_total     = timing_q.h_total;
  assign h_sync      = timing_q.h_sync;
  assign h_start     = timing_q.h_start;
  assign h_end       = timing_q.h_end;
  assign v_total     = timing_q.v_total;
  assign v_sync      = timing_q.v_sync;
  assign v_start     = timing_q.v_start;
  assign v_end       = timing_q.v_end;
  assign v_active_14 = va14_q;
  assign v_active_24 = va24_q;
  assign v_active_34 = va34_q;

endmodule

// File: tb/tb_vga_mode_ctrl.sv
`timescale 1ns/1ps
// Directed bench for vga_mode_ctrl: startup, mode change on a frame boundary,
// same-mode request, VS timeout, ignored mid-sequence request, reset abort.
module tb_vga_mode_ctrl;

  localparam int BLANK_CYCLES  = 16;
  localparam int SETTLE_FRAMES = 2;
  localparam int VS_TIMEOUT    = 300;
  localparam int HALF          = 30;   // half of a synthetic vsync period

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mode_req = 1'b0;
  logic [1:0]  mode_sel = 2'd0;
  logic        vga_vs_in = 1'b1;
  logic        mode_ack, busy, gen_reset_n;
  logic [1:0]  cur_mode;
  logic [11:0] h_total, h_sync, h_start, h_end;
  logic [11:0] v_total, v_sync, v_start, v_end;
  logic [11:0] v_active_14, v_active_24, v_active_34;

  int errors = 0;
  int checks = 0;
  int acks   = 0;   // mode_ack pulses seen at sample points
  int ack_base;
  int n;

  vga_mode_ctrl #(
    .BLANK_CYCLES (BLANK_CYCLES),
    .SETTLE_FRAMES(SETTLE_FRAMES),
    .VS_TIMEOUT   (VS_TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mode_req   (mode_req),
    .mode_sel   (mode_sel),
    .vga_vs_in  (vga_vs_in),
    .mode_ack   (mode_ack),
    .busy       (busy),
    .cur_mode   (cur_mode),
    .gen_reset_n(gen_reset_n),
    .h_total    (h_total),
    .h_sync     (h_sync),
    .h_start    (h_start),
    .h_end      (h_end),
    .v_total    (v_total),
    .v_sync     (v_sync),
    .v_start    (v_start),
    .v_end      (v_end),
    .v_active_14(v_active_14),
    .v_active_24(v_active_24),
    .v_active_34(v_active_34)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One sample point per cycle, on the falling edge.
  task automatic cyc();
    @(negedge clk);
    if (mode_ack === 1'b1) acks++;
  endtask

  task automatic frame();
    vga_vs_in = 1'b1;
    repeat (HALF) cyc();
    vga_vs_in = 1'b0;
    repeat (HALF) cyc();
  endtask

  task automatic wait_gen(input logic lvl, input string tag);
    int k = 0;
    while (gen_reset_n !== lvl && k < 1000) begin
      cyc();
      k++;
    end
    check(tag, 32'(gen_reset_n), 32'(lvl));
  endtask

  // Counts consecutive low samples of gen_reset_n starting at the current one.
  task automatic count_low(output int cnt);
    cnt = 0;
    while (gen_reset_n === 1'b0 && cnt < 200) begin
      cnt++;
      cyc();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Startup: reset values, 16-cycle generator reset, two frames, no ack.
    repeat (3) cyc();
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_gen_reset_n", 32'(gen_reset_n), 32'd0);
    check("rst_cur_mode", 32'(cur_mode), 32'd0);
    check("rst_mode_ack", 32'(mode_ack), 32'd0);
    check("rst_h_total", 32'(h_total), 32'd799);
    check("rst_v_end", 32'(v_end), 32'd514);
    check("rst_va14", 32'(v_active_14), 32'd154);
    check("rst_va24", 32'(v_active_24), 32'd274);
    check("rst_va34", 32'(v_active_34), 32'd394);
    ack_base = acks;
    reset = 1'b0;
    count_low(n);
    check("startup_low_len", 32'(n), 32'd16);
    check("startup_va14", 32'(v_active_14), 32'd154);
    frame();
    check("startup_busy_1frame", 32'(busy), 32'd1);
    frame();
    check("startup_busy_done", 32'(busy), 32'd0);
    check("startup_cur_mode", 32'(cur_mode), 32'd0);
    check("startup_no_ack", 32'(acks - ack_base), 32'd0);

    // Mode 2 change released by a frame boundary.
    ack_base = acks;
    mode_sel = 2'd2;
    mode_req = 1'b1;
    cyc();
    mode_req = 1'b0;
    check("m2_busy_rise", 32'(busy), 32'd1);
    check("m2_wait_gen_high", 32'(gen_reset_n), 32'd1);
    vga_vs_in = 1'b1;
    repeat (HALF) cyc();
    vga_vs_in = 1'b0;
    wait_gen(1'b0, "m2_blank_start");
    count_low(n);
    check("m2_low_len", 32'(n), 32'd16);
    check("m2_h_total", 32'(h_total), 32'd1649);
    check("m2_h_end", 32'(h_end), 32'd1539);
    check("m2_va14", 32'(v_active_14), 32'd204);
    check("m2_va24", 32'(v_active_24), 32'd384);
    check("m2_va34", 32'(v_active_34), 32'd564);
    check("m2_cur_mode_pending", 32'(cur_mode), 32'd0);
    frame();
    check("m2_busy_1frame", 32'(busy), 32'd1);
    frame();
    check("m2_busy_done", 32'(busy), 32'd0);
    check("m2_cur_mode", 32'(cur_mode), 32'd2);
    check("m2_ack_count", 32'(acks - ack_base), 32'd1);

    // Same-mode request: immediate ack, no reconfiguration.
    mode_sel = 2'd2;
    mode_req = 1'b1;
    cyc();
    mode_req = 1'b0;
    check("same_ack_pulse", 32'(mode_ack), 32'd1);
    check("same_busy", 32'(busy), 32'd0);
    check("same_gen_reset_n", 32'(gen_reset_n), 32'd1);
    cyc();
    check("same_ack_drop", 32'(mode_ack), 32'd0);
    check("same_h_total", 32'(h_total), 32'd1649);

    // Mode 3 with vsync stuck: BLANK after exactly VS_TIMEOUT cycles.
    ack_base = acks;
    mode_sel = 2'd3;
    mode_req = 1'b1;
    cyc();
    mode_req = 1'b0;
    n = 0;
    while (gen_reset_n === 1'b1 && n < 1000) begin
      if (busy === 1'b1) n++;
      cyc();
    end
    check("to_wait_len", 32'(n), 32'(VS_TIMEOUT));
    wait_gen(1'b1, "to_release");
    check("to_h_total", 32'(h_total), 32'd2199);
    check("to_va14", 32'(v_active_14), 32'd310);
    check("to_va34", 32'(v_active_34), 32'd850);
    frame();
    frame();
    check("to_cur_mode", 32'(cur_mode), 32'd3);
    check("to_ack_count", 32'(acks - ack_base), 32'd1);

    // Request during SETTLE is ignored; original target completes.
    ack_base = acks;
    mode_sel = 2'd2;
    mode_req = 1'b1;
    cyc();
    mode_req = 1'b0;
    frame();
    wait_gen(1'b1, "ign_release");
    mode_sel = 2'd1;
    mode_req = 1'b1;
    repeat (3) cyc();
    mode_req = 1'b0;
    frame();
    check("ign_busy_1frame", 32'(busy), 32'd1);
    frame();
    check("ign_busy_done", 32'(busy), 32'd0);
    check("ign_cur_mode", 32'(cur_mode), 32'd2);
    check("ign_h_total", 32'(h_total), 32'd1649);
    check("ign_ack_count", 32'(acks - ack_base), 32'd1);

    // Reset during BLANK of a mode 1 change aborts without ack.
    mode_sel = 2'd1;
    mode_req = 1'b1;
    cyc();
    mode_req = 1'b0;
    vga_vs_in = 1'b1;
    repeat (HALF) cyc();
    vga_vs_in = 1'b0;
    wait_gen(1'b0, "abort_blank_start");
    repeat (4) cyc();
    check("abort_in_blank_h_total", 32'(h_total), 32'd1649);
    ack_base = acks;
    reset = 1'b1;
    repeat (2) cyc();
    check("abort_h_total", 32'(h_total), 32'd799);
    check("abort_va14", 32'(v_active_14), 32'd154);
    check("abort_cur_mode", 32'(cur_mode), 32'd0);
    check("abort_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    count_low(n);
    check("abort_low_len", 32'(n), 32'd16);
    frame();
    frame();
    check("abort_busy_done", 32'(busy), 32'd0);
    check("abort_cur_mode_final", 32'(cur_mode), 32'd0);
    check("abort_no_ack", 32'(acks - ack_base), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_mode_ctrl.md
VGA_MODE_CTRL -- requirements
Module: vga_mode_ctrl

Interface
REQ-001 Parameter BLANK_CYCLES, default 16: cycles gen_reset_n is held low per reconfiguration (min 4).
REQ-002 Parameter SETTLE_FRAMES, default 2: generator frames counted after release before completion (min 1).
REQ-003 Parameter VS_TIMEOUT, default 2000000: maximum cycles to wait for a frame boundary before forcing reconfiguration.
REQ-004 clk  in  1  single clock; all logic is on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 mode_req  in  1  level request to change video mode.
REQ-007 mode_sel  in  2  requested mode index; sampled only when a request is accepted.
REQ-008 vga_vs_in  in  1  vga_vs fed back from the timing generator.
REQ-009 mode_ack  out  1  one-cycle pulse when a request completes.
REQ-010 busy  out  1  high while any reconfiguration or startup sequence is in progress.
REQ-011 cur_mode  out  2  mode currently driving the generator.
REQ-012 gen_reset_n  out  1  active-low reset to the timing generator.
REQ-013 h_total, h_sync, h_start, h_end, v_total, v_sync, v_start, v_end  out  12 each  registered timing values to the generator.
REQ-014 v_active_14, v_active_24, v_active_34  out  12 each  registered quarter-band boundaries to the generator.

Function
REQ-015 Mode table (h_total/h_sync/h_start/h_end/v_total/v_sync/v_start/v_end): 0 = 799/95/141/781/524/1/34/514; 1 = 1055/127/213/1013/627/3/26/626; 2 = 1649/39/259/1539/749/4/24/744; 3 = 2199/43/189/2109/1124/4/40/1120.
REQ-016 States: IDLE, WAIT_VS, BLANK, LOAD, CALC, SETTLE, DONE.
REQ-017 Frame boundary: a falling edge of vga_vs_in, detected from a registered copy; detection latency is 1 cycle.
REQ-018 IDLE with mode_req=1 and mode_sel!=cur_mode: capture target=mode_sel, set ack_pending, busy=1 next cycle, go to WAIT_VS.
REQ-019 IDLE with mode_req=1 and mode_sel==cur_mode: mode_ack pulses the next cycle; no reconfiguration; busy stays 0.
REQ-020 WAIT_VS: go to BLANK on a frame boundary, or after VS_TIMEOUT cycles in WAIT_VS if none occurs; gen_reset_n is still 1.
REQ-021 BLANK: gen_reset_n=0 for exactly BLANK_CYCLES cycles, then go to LOAD.
REQ-022 LOAD (1 cycle): the eight timing outputs take the table values for target.
REQ-023 CALC (1 cycle): q=(v_end-v_start)>>2 as 12-bit unsigned; v_active_14=v_start+q; v_active_24=v_start+2q; v_active_34=v_start+3q; each truncated to 12 bits.
REQ-024 On leaving CALC, gen_reset_n=1 and go to SETTLE; timing outputs change only in LOAD/CALC while gen_reset_n=0.
REQ-025 SETTLE: count frame boundaries; at SETTLE_FRAMES go to DONE; no timeout applies.
REQ-026 DONE (1 cycle): cur_mode=target; mode_ack=ack_pending; clear ack_pending; busy=0 next cycle; go to IDLE.
REQ-027 mode_req and mode_sel are ignored outside IDLE; a request still high after ack with a new mode_sel starts a new sequence.
REQ-028 mode_ack is never asserted for the startup sequence.

Reset
REQ-029 Reset values: state=BLANK, target=0, cur_mode=0, ack_pending=0, mode_ack=0, busy=1, gen_reset_n=0, all counters 0, timing outputs = mode 0 values with v_active_14/24/34=154/274/394.
REQ-030 After reset deasserts, the startup sequence runs BLANK->LOAD->CALC->SETTLE->DONE for mode 0, then enters IDLE.
REQ-031 Reset asserted mid-sequence aborts it with no mode_ack, and the block restarts as in REQ-029 and REQ-030.

Verification
REQ-032 Reset, then toggle vga_vs_in every 1000 cycles -> gen_reset_n low for 16 cycles after reset; busy falls after the 2nd boundary; cur_mode=0; no mode_ack.
REQ-033 IDLE, mode_req=1 with mode_sel=2 -> WAIT_VS, then 16 cycles gen_reset_n=0; h_total=1649, v_active_14/24/34=204/384/564; ack after 2 boundaries; cur_mode=2.
REQ-034 mode_sel==cur_mode with mode_req=1 -> mode_ack pulses the next cycle; gen_reset_n stays 1; outputs unchanged.
REQ-035 vga_vs_in held constant, mode_sel=3 -> BLANK entered after exactly VS_TIMEOUT cycles; h_total=2199, v_active_14=310.
REQ-036 mode_sel changed and mode_req pulsed during SETTLE -> ignored; completion reports the original target.
REQ-037 reset asserted during BLANK of a mode 1 change -> no mode_ack; outputs revert to mode 0; startup repeats.
